mux_4x1_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one 4:1 output channel among four requesters (a, b, c, d).
- Generates the registered mux select and a one-hot grant.
- Drives the selected requester's data onto out, qualified by valid.
- Sits in front of the CO datapath mux so several sources can time-share one bus with bounded burst length.

---
 rtl/mux_4x1_rr_arbiter_if.sv | 25 ++
 rtl/mux_4x1_rr_arbiter.sv | 100 ++++++++++
 tb/tb_mux_4x1_rr_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mux_4x1_rr_arbiter_if.sv
// Bus bundle between four requesters and the round-robin 4:1 output channel.
// The master side drives requests and data; the slave side is the arbiter.
interface mux_4x1_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       req;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic             valid;
  logic [WIDTH-1:0] out;

  modport master (
    output req, a, b, c, d,
    input  gnt, sel, valid, out
  );

  modport slave (
    input  req, a, b, c, d,
    output gnt, sel, valid, out
  );
endinterface

// File: rtl/mux_4x1_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 output channel among requesters a..d,
// with a per-holder burst limit and a registered select/one-hot grant.
module mux_4x1_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input logic                  clk,
  input logic                  rst,
  mux_4x1_rr_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_n;
  logic [1:0] sel_q, sel_n;
  logic [1:0] last_q, last_n;
  logic [3:0] gnt_q, gnt_n;
  logic [7:0] cnt_q, cnt_n;

  logic [1:0] scan_idx;
  logic [1:0] win;
  logic       found;
  logic       rearb;

  // First requester after the last-served index; the last-served one comes last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found    = 1'b0;
    win      = last_q;
    scan_idx = last_q;
    for (int i = 1; i <= 4; i++) begin
      scan_idx = last_q + 2'(i);
      if (!found && bus.req[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

  // IDLE always arbitrates; GRANT only when the holder drops or hits its burst limit.
  always_comb begin
    state_n = state_q;
    sel_n   = sel_q;
    last_n  = last_q;
    gnt_n   = gnt_q;
    cnt_n   = cnt_q;
    rearb   = (state_q == IDLE) || !bus.req[sel_q] || (cnt_q == 8'(MAX_BURST));

    if (rearb) begin
      if (found) begin
        state_n = GRANT;
        sel_n   = win;
        last_n  = win;
        gnt_n   = 4'b0001 << win;
        cnt_n   = 8'd1;
      end else begin
        state_n = IDLE;
        gnt_n   = 4'b0000;
        cnt_n   = 8'd0;
      end
    end else begin
      cnt_n = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      gnt_q   <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      last_q  <= last_n;
      gnt_q   <= gnt_n;
      cnt_q   <= cnt_n;
    end
  end

  assign bus.gnt = gnt_q;
  assign bus.sel = sel_q;

  // Data is qualified by the holder's live request, so a dropped req blanks out immediately.
  always_comb begin
    bus.valid = (state_q == GRANT) && bus.req[sel_q];
    bus.out   = '0;
    if (bus.valid) begin
      unique case (sel_q)
        2'd0: bus.out = bus.a;
        2'd1: bus.out = bus.b;
        2'd2: bus.out = bus.c;
        2'd3: bus.out = bus.d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Scoreboard bench for mux_4x1_rr_arbiter: a driver advances a behavioural
// holder/pointer model and queues expectations; a monitor compares mid-cycle.
module tb_mux_4x1_rr_arbiter;
  localparam int WIDTH     = 4;
  localparam int MAX_BURST = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_4x1_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();

  mux_4x1_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int               cyc;
    logic [3:0]       gnt;
    logic [1:0]       sel;
    bit               sel_chk;
    logic             valid;
    logic [WIDTH-1:0] out;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;
  int   pushes = 0;
  int   pops   = 0;

  // Model: who holds the channel (-1 = nobody), how long, and who was served last.
  int m_hold      = -1;
  int m_cnt       = 0;
  int m_last      = 3;
  int m_sel       = 0;
  bit m_sel_known = 1'b1;

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs after the edge, queue what the outputs must be
  // during this cycle, then move the model across the next edge.
  task automatic step(input logic r, input logic [3:0] rq, input bit rnd_data);
    logic [WIDTH-1:0] dv [4];
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) dv[i] = rnd_data ? WIDTH'($urandom) : WIDTH'(i);
    rst     = r;
    bus.req = rq;
    bus.a   = dv[0];
    bus.b   = dv[1];
    bus.c   = dv[2];
    bus.d   = dv[3];

    e.cyc     = cyc_n;
    e.gnt     = (m_hold < 0) ? 4'b0000 : 4'(1 << m_hold);
    e.sel     = 2'(m_sel);
    e.sel_chk = m_sel_known;
    e.valid   = (m_hold >= 0) && rq[m_hold];
    e.out     = e.valid ? dv[m_hold] : '0;
    sb.push_back(e);
    pushes++;
    cyc_n++;

    if (r) begin
      m_hold = -1; m_cnt = 0; m_last = 3; m_sel = 0; m_sel_known = 1'b1;
    end else if (m_hold < 0 || !rq[m_hold] || m_cnt == MAX_BURST) begin
      w = -1;
      for (int k = 1; k <= 4; k++)
        if (w < 0 && rq[(m_last + k) % 4]) w = (m_last + k) % 4;
      if (w >= 0) begin
        m_hold = w; m_last = w; m_sel = w; m_sel_known = 1'b1; m_cnt = 1;
      end else begin
        if (m_hold >= 0) m_sel_known = 1'b0;
        m_hold = -1;
        m_cnt  = 0;
      end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic run(input logic [3:0] rq, input int n);
    for (int i = 0; i < n; i++) step(1'b0, rq, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        pops++;
        check("gnt",   e.cyc, 32'(bus.gnt),   32'(e.gnt));
        check("valid", e.cyc, 32'(bus.valid), 32'(e.valid));
        check("out",   e.cyc, 32'(bus.out),   32'(e.out));
        if (e.sel_chk) check("sel", e.cyc, 32'(bus.sel), 32'(e.sel));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc_n);
    $fatal(1);
  end

  initial begin
    bus.req = 4'b0000;
    bus.a = '0; bus.b = '0; bus.c = '0; bus.d = '0;

    // Reset held with everyone requesting.
    step(1'b1, 4'b1111, 1'b0);
    step(1'b1, 4'b1111, 1'b0);

    // Lone requester keeps the channel across burst boundaries.
    run(4'b0100, 12);

    // Everyone requesting: four-cycle bursts in index order.
    step(1'b1, 4'b0000, 1'b0);
    run(4'b1111, 20);

    // Holder drops on its second grant cycle.
    step(1'b1, 4'b0000, 1'b0);
    run(4'b1001, 2);
    run(4'b1000, 3);

    // Reset mid-burst, then the pointer is back at 3.
    step(1'b1, 4'b0000, 1'b0);
    run(4'b0010, 3);
    step(1'b1, 4'b0010, 1'b0);
    run(4'b1010, 4);

    // Pointer fairness after index 2 was served.
    step(1'b1, 4'b0000, 1'b0);
    run(4'b0100, 2);
    run(4'b0000, 1);
    run(4'b0101, 8);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic [3:0] rq;
      for (int j = 0; j < 4; j++) rq[j] = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) rq = 4'b0000;
      step(($urandom_range(0, 63) == 0), rq, 1'b1);
    end

    repeat (3) @(negedge clk);
    check("drain", cyc_n, 32'(pops), 32'(pushes));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
